// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - IR word format: opcodes, field positions, field struct, legality check
// Imported by ir_pack and ir_encoder_loader. No ports.
package ir_pkg;

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_ROR     = 5'd5;
    localparam logic [4:0] OP_RAND    = 5'd6;
    localparam logic [4:0] OP_RXOR    = 5'd7;
    localparam logic [4:0] OP_RXNOR   = 5'd8;
    localparam logic [4:0] OP_RNAND   = 5'd9;
    localparam logic [4:0] OP_RNOR    = 5'd10;
    localparam logic [4:0] OP_RNOT    = 5'd11;

    localparam int OPER_MSB  = 31;
    localparam int OPER_LSB  = 27;
    localparam int RDST_MSB  = 26;
    localparam int RDST_LSB  = 22;
    localparam int RSRC1_MSB = 21;
    localparam int RSRC1_LSB = 17;
    localparam int MODE_BIT  = 16;
    localparam int RSRC2_MSB = 15;
    localparam int RSRC2_LSB = 11;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;

    typedef struct packed {
        logic [4:0]  oper;
        logic [4:0]  rdst;
        logic [4:0]  rsrc1;
        logic        imm_mode;
        logic [4:0]  rsrc2;
        logic [15:0] imm;
    } ir_fields_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ir_state_t;

    function automatic logic is_legal_op(input logic [4:0] op);
        case (op)
            OP_MOVSGPR, OP_MOV, OP_ADD, OP_SUB, OP_MUL, OP_ROR,
            OP_RAND, OP_RXOR, OP_RXNOR, OP_RNAND, OP_RNOR, OP_RNOT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ir_pack.sv
// rtl/ir_pack.sv - combinational packer from decoded fields to a 32-bit IR word
// Ports: fields_i (decoded fields), word_o (packed IR word).
module ir_pack
    import ir_pkg::*;
(
    input  ir_fields_t  fields_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = '0;
        word_o[OPER_MSB:OPER_LSB]   = fields_i.oper;
        word_o[RDST_MSB:RDST_LSB]   = fields_i.rdst;
        word_o[RSRC1_MSB:RSRC1_LSB] = fields_i.rsrc1;
        word_o[MODE_BIT]            = fields_i.imm_mode;
        // Only the field selected by the mode bit reaches the word; [10:0] stay zero in register form.
        if (fields_i.imm_mode) begin
            word_o[IMM_MSB:IMM_LSB] = fields_i.imm;
        end else begin
            word_o[RSRC2_MSB:RSRC2_LSB] = fields_i.rsrc2;
        end
    end

endmodule

// File: rtl/ir_encoder_loader.sv
// rtl/ir_encoder_loader.sv - packs field beats into IR words and writes them to instruction memory
// Ports: clk, rst_n; start; in_* field stream with in_valid/in_ready/in_last;
//        mem_we/mem_addr/mem_wdata write port; busy, done, word_count, err_illegal status.
// Optional: IR_ENC_OPCHECK_EN drops beats with illegal opcodes and flags err_illegal.
module ir_encoder_loader
    import ir_pkg::*;
#(
    parameter  int DEPTH     = 32,
    parameter  int BASE_ADDR = 0,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_oper,
    input  logic [4:0]    in_rdst,
    input  logic [4:0]    in_rsrc1,
    input  logic          in_imm_mode,
    input  logic [4:0]    in_rsrc2,
    input  logic [15:0]   in_imm,
    input  logic          in_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   word_count,
    output logic          err_illegal
);

    ir_state_t   state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   packed_word;
    logic          accept;
    logic          op_ok;

    ir_fields_t fields;
    assign fields = {in_oper, in_rdst, in_rsrc1, in_imm_mode, in_rsrc2, in_imm};

    ir_pack u_pack (
        .fields_i (fields),
        .word_o   (packed_word)
    );

    // in_ready_q is only ever high in LOAD, so it alone qualifies acceptance.
    assign accept = in_valid && in_ready_q;

`ifdef IR_ENC_OPCHECK_EN
    logic err_q, err_d;
    assign op_ok       = is_legal_op(in_oper);
    assign err_illegal = err_q;
`else
    assign op_ok       = 1'b1;
    assign err_illegal = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef IR_ENC_OPCHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    ptr_d   = AW'(BASE_ADDR);
                    count_d = '0;
`ifdef IR_ENC_OPCHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (op_ok) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = packed_word;
                        ptr_d   = ptr_q + AW'(1);
                        count_d = count_q + (AW+1)'(1);
                    end
`ifdef IR_ENC_OPCHECK_EN
                    else begin
                        err_d = 1'b1;
                    end
`endif
                    // A write into the top slot ends the session so the pointer never wraps.
                    if (in_last || (op_ok && ptr_q == AW'(DEPTH - 1))) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= AW'(BASE_ADDR);
            count_q    <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= AW'(BASE_ADDR);
            wdata_q    <= '0;
`ifdef IR_ENC_OPCHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef IR_ENC_OPCHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign word_count = count_q;
    assign busy       = (state_q == ST_LOAD);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_ir_encoder_loader.sv
// tb/tb_ir_encoder_loader.sv - self-checking bench for ir_encoder_loader
module tb_ir_encoder_loader;

    localparam int DEPTH = 32;
    localparam int BASE  = 0;
    localparam int AW    = 5;
`ifdef IR_ENC_OPCHECK_EN
    localparam bit OPCHECK = 1'b1;
`else
    localparam bit OPCHECK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_oper = '0;
    logic [4:0]    in_rdst = '0;
    logic [4:0]    in_rsrc1 = '0;
    logic          in_imm_mode = 1'b0;
    logic [4:0]    in_rsrc2 = '0;
    logic [15:0]   in_imm = '0;
    logic          in_last = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic [AW:0]   word_count;
    logic          err_illegal;

    ir_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_oper(in_oper), .in_rdst(in_rdst), .in_rsrc1(in_rsrc1),
        .in_imm_mode(in_imm_mode), .in_rsrc2(in_rsrc2), .in_imm(in_imm),
        .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .word_count(word_count), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t wlog[$];
    wr_t wexp[$];

    always @(negedge clk) begin
        if (rst_n && mem_we) wlog.push_back({mem_addr, mem_wdata});
    end

    int checks = 0;
    int errors = 0;
    int m_ptr, m_count;
    bit m_done, m_err;

    function automatic logic [31:0] model_word(input logic [4:0] oper, input logic [4:0] rdst,
                                               input logic [4:0] rs1, input logic mode,
                                               input logic [4:0] rs2, input logic [15:0] imm);
        longint w;
        w = longint'(oper) * 134217728 + longint'(rdst) * 4194304 + longint'(rs1) * 131072;
        if (mode) w = w + 65536 + longint'(imm);
        else      w = w + longint'(rs2) * 2048;
        return w[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [4:0] oper, input logic [4:0] rdst, input logic [4:0] rs1,
                                input logic mode, input logic [4:0] rs2, input logic [15:0] imm,
                                input logic last);
        bit legal;
        legal = !OPCHECK || (int'(oper) < 12);
        if (legal) begin
            wexp.push_back({AW'(m_ptr), model_word(oper, rdst, rs1, mode, rs2, imm)});
            m_ptr++;
            m_count++;
        end else begin
            m_err = 1'b1;
        end
        if (last || m_ptr == DEPTH) m_done = 1'b1;
    endtask

    task automatic session_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_ptr = BASE; m_count = 0; m_done = 1'b0; m_err = 1'b0;
        wlog.delete();
        wexp.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
    task automatic beat(input logic [4:0] oper, input logic [4:0] rdst, input logic [4:0] rs1,
                        input logic mode, input logic [4:0] rs2, input logic [15:0] imm,
                        input logic last);
        int n;
        in_oper = oper; in_rdst = rdst; in_rsrc1 = rs1; in_imm_mode = mode;
        in_rsrc2 = rs2; in_imm = imm; in_last = last; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 50) else begin
            errors++;
            $error("FAIL ready_timeout: observed waited %0d cycles expected under 50", n);
        end
        @(negedge clk);
        model_accept(oper, rdst, rs1, mode, rs2, imm, last);
    endtask

    task automatic rand_beat(input logic last, input int max_op);
        beat(5'($urandom_range(0, max_op)), 5'($urandom), 5'($urandom), 1'($urandom),
             5'($urandom), 16'($urandom), last);
    endtask

    task automatic check_writes(input string tag);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_nwrites"}, 64'(wlog.size()), 64'(wexp.size()));
        for (int i = 0; i < wlog.size() && i < wexp.size(); i++) begin
            chk({tag, "_addr"}, 64'(wlog[i].addr), 64'(wexp[i].addr));
            chk({tag, "_data"}, 64'(wlog[i].data), 64'(wexp[i].data));
        end
        chk({tag, "_count"}, 64'(word_count), 64'(m_count));
        chk({tag, "_done"},  64'(done), 64'(m_done));
        chk({tag, "_err"},   64'(err_illegal), 64'(m_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n;
        bit acc;
        logic [4:0] f_op, f_rd, f_r1, f_r2;
        logic f_md;
        logic [15:0] f_im;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_mem_we", 64'(mem_we), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err_illegal), 0);
        chk("rst_addr", 64'(mem_addr), 64'(BASE));
        chk("rst_wdata", 64'(mem_wdata), 0);
        chk("rst_count", 64'(word_count), 0);
        rst_n = 1'b1;

        // beat offered in IDLE is not taken
        @(negedge clk);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 64'(in_ready), 0);
        chk("idle_no_write", 64'(wlog.size()), 0);
        in_valid = 1'b0;

        // immediate pack: add r3,r1,#0x00FF, last
        session_start();
        chk("load_busy", 64'(busy), 1);
        chk("load_ready", 64'(in_ready), 1);
        beat(5'd2, 5'd3, 5'd1, 1'b1, 5'd0, 16'h00FF, 1'b1);
        in_valid = 1'b0;
        chk("imm_we", 64'(mem_we), 1);
        chk("imm_addr", 64'(mem_addr), 0);
        chk("imm_wdata", 64'(mem_wdata), 64'h10C300FF);
        chk("imm_done", 64'(done), 1);
        @(negedge clk);
        chk("imm_we_single", 64'(mem_we), 0);
        chk("imm_ready_low", 64'(in_ready), 0);
        check_writes("imm");

        // register pack, immediate must not leak
        session_start();
        beat(5'd3, 5'd4, 5'd2, 1'b0, 5'd7, 16'hFFFF, 1'b1);
        chk("reg_wdata", 64'(mem_wdata), 64'h19043800);
        check_writes("reg");

        // full stop after DEPTH writes
        session_start();
        acc_n = 0;
        for (int i = 0; i < 40; i++) begin
            f_op = 5'($urandom_range(0, 11)); f_rd = 5'($urandom); f_r1 = 5'($urandom);
            f_md = 1'($urandom); f_r2 = 5'($urandom); f_im = 16'($urandom);
            in_oper = f_op; in_rdst = f_rd; in_rsrc1 = f_r1; in_imm_mode = f_md;
            in_rsrc2 = f_r2; in_imm = f_im; in_last = 1'b0; in_valid = 1'b1;
            acc = in_ready;
            @(negedge clk);
            if (acc) begin
                acc_n++;
                model_accept(f_op, f_rd, f_r1, f_md, f_r2, f_im, 1'b0);
            end
        end
        chk("full_accepts", 64'(acc_n), 64'(DEPTH));
        chk("full_ready_low", 64'(in_ready), 0);
        check_writes("full");

        // gaps: valid 1,0,1,1
        session_start();
        rand_beat(1'b0, 11);
        in_valid = 1'b0;
        @(negedge clk);
        rand_beat(1'b0, 11);
        rand_beat(1'b1, 11);
        check_writes("gaps");

        // start during LOAD ignored
        session_start();
        rand_beat(1'b0, 11);
        rand_beat(1'b0, 11);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_load_busy", 64'(busy), 1);
        rand_beat(1'b1, 11);
        check_writes("start_ignored");

        // illegal opcode in the middle
        session_start();
        beat(5'd2, 5'd1, 5'd2, 1'b0, 5'd3, 16'h0, 1'b0);
        beat(5'd20, 5'd1, 5'd2, 1'b0, 5'd3, 16'h0, 1'b0);
        beat(5'd5, 5'd1, 5'd2, 1'b0, 5'd3, 16'h0, 1'b1);
        check_writes("illegal");
        session_start();
        chk("err_cleared", 64'(err_illegal), 0);
        in_valid = 1'b0;

        // randomized sessions including illegal opcodes and gaps
        for (int s = 0; s < 4; s++) begin
            int len;
            if (s > 0) session_start();
            len = $urandom_range(1, 10);
            for (int b = 0; b < len; b++) begin
                rand_beat(1'(b == len - 1), 31);
                if ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            check_writes("rand");
        end

        // asynchronous reset mid-session
        session_start();
        rand_beat(1'b0, 11);
        rand_beat(1'b0, 11);
        rand_beat(1'b0, 11);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_we", 64'(mem_we), 0);
        chk("arst_ready", 64'(in_ready), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_count", 64'(word_count), 0);
        chk("arst_addr", 64'(mem_addr), 64'(BASE));
        chk("arst_wdata", 64'(mem_wdata), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        session_start();
        beat(5'd1, 5'd9, 5'd8, 1'b1, 5'd0, 16'h1234, 1'b1);
        in_valid = 1'b0;
        chk("arst_restart_addr", 64'(mem_addr), 64'(BASE));
        check_writes("arst_restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
